// File: rtl/exec_mc.sv
// Multi-cycle execute stage: registers one decoded instruction, runs the ALU or an
// iterative shift-add multiplier, and resolves branches, jumps and dmem addresses.
module exec_mc #(
  parameter int unsigned IALU_WORD_WIDTH    = 16,
  parameter int unsigned DMEM_ADDR_WIDTH    = 12,
  parameter int unsigned PC_WIDTH           = 12,
  parameter int unsigned REG_IDX_WIDTH      = 4,
  parameter int unsigned ALU_OP_WIDTH       = 4,
  parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ALU_OP_WIDTH-1:0]    in_alu_op,
  input  logic                       in_flush,
  input  logic [IALU_WORD_WIDTH-1:0] in_src1,
  input  logic [IALU_WORD_WIDTH-1:0] in_src2,
  input  logic [IALU_WORD_WIDTH-1:0] in_src3,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  input  logic                       in_act_write_res_to_reg,
  input  logic                       in_act_load_dmem,
  input  logic                       in_act_store_dmem,
  input  logic                       in_act_jump_to_ialu_res,
  input  logic                       in_act_branch_eq0,
  input  logic                       in_act_branch_gt0,
  input  logic                       in_act_branch_lt0,
  output logic                       out_stall,
  output logic                       out_valid,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic                       out_act_write_res_to_reg,
  output logic                       out_act_load_dmem,
  output logic                       out_act_store_dmem,
  output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_rd_addr,
  output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_wr_addr,
  output logic [IALU_WORD_WIDTH-1:0] out_dmem_wr_word,
  output logic                       out_set_pc,
  output logic                       out_flush,
  output logic [PC_WIDTH-1:0]        out_branch_pc
);

  localparam int unsigned W    = IALU_WORD_WIDTH;
  localparam int unsigned B    = MUL_BITS_PER_CYCLE;
  localparam int unsigned N    = W / B;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ShW  = $clog2(W);

  localparam logic [ALU_OP_WIDTH-1:0] OpAdd  = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] OpSub  = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] OpAnd  = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] OpOr   = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] OpXor  = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] OpSll  = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] OpSrl  = ALU_OP_WIDTH'(6);
  localparam logic [ALU_OP_WIDTH-1:0] OpSra  = ALU_OP_WIDTH'(7);
  localparam logic [ALU_OP_WIDTH-1:0] OpPass = ALU_OP_WIDTH'(8);
  localparam logic [ALU_OP_WIDTH-1:0] OpMul  = ALU_OP_WIDTH'(9);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // live is cleared for captured flushes, so every output gates on it
  typedef struct packed {
    logic                     live;
    logic [ALU_OP_WIDTH-1:0]  op;
    logic [W-1:0]             src1;
    logic [W-1:0]             src2;
    logic [W-1:0]             src3;
    logic [PC_WIDTH-1:0]      pc;
    logic [REG_IDX_WIDTH-1:0] idx;
    logic                     wr;
    logic                     ld;
    logic                     st;
    logic                     jmp;
    logic                     beq;
    logic                     bgt;
    logic                     blt;
  } stage_t;

  state_e         state_q;
  stage_t         stage_q;
  logic [W-1:0]   acc_q, mcand_q, mplier_q;
  logic [CntW-1:0] cnt_q;

  logic           busy, valid, cond, take_branch;
  logic [W-1:0]   pp, res;
  logic [ShW-1:0] shamt;

  assign busy  = (state_q == StBusy);
  assign valid = stage_q.live && !busy;

  // Partial product of the next MUL_BITS_PER_CYCLE multiplier bits
  always_comb begin
    pp = '0;
    for (int i = 0; i < B; i++) begin
      if (mplier_q[i]) pp = pp + (mcand_q << i);
    end
  end

  always_comb begin
    shamt = stage_q.src2[ShW-1:0];
    res   = '0;
    case (stage_q.op)
      OpAdd:   res = stage_q.src1 + stage_q.src2;
      OpSub:   res = stage_q.src1 - stage_q.src2;
      OpAnd:   res = stage_q.src1 & stage_q.src2;
      OpOr:    res = stage_q.src1 | stage_q.src2;
      OpXor:   res = stage_q.src1 ^ stage_q.src2;
      OpSll:   res = stage_q.src1 << shamt;
      OpSrl:   res = stage_q.src1 >> shamt;
      OpSra:   res = $unsigned($signed(stage_q.src1) >>> shamt);
      OpPass:  res = stage_q.src2;
      OpMul:   res = acc_q;
      default: res = '0;
    endcase
  end

  always_comb begin
    cond = (stage_q.beq && (res == '0)) ||
           (stage_q.bgt && !res[W-1] && (res != '0)) ||
           (stage_q.blt && res[W-1]);
    take_branch = valid && (stage_q.jmp || cond);
  end

  always_comb begin
    out_stall                = busy;
    out_valid                = valid;
    out_res                  = '0;
    out_res_reg_idx          = '0;
    out_pc                   = '0;
    out_act_write_res_to_reg = 1'b0;
    out_act_load_dmem        = 1'b0;
    out_act_store_dmem       = 1'b0;
    out_dmem_rd_addr         = '0;
    out_dmem_wr_addr         = '0;
    out_dmem_wr_word         = '0;
    out_set_pc               = take_branch;
    out_flush                = take_branch;
    out_branch_pc            = '0;
    if (valid) begin
      out_res                  = res;
      out_res_reg_idx          = stage_q.idx;
      out_pc                   = stage_q.pc;
      out_act_write_res_to_reg = stage_q.wr;
      out_act_load_dmem        = stage_q.ld;
      out_act_store_dmem       = stage_q.st;
      if (stage_q.ld) out_dmem_rd_addr = stage_q.src1[DMEM_ADDR_WIDTH-1:0];
      if (stage_q.st) begin
        out_dmem_wr_addr = res[DMEM_ADDR_WIDTH-1:0];
        out_dmem_wr_word = stage_q.src3;
      end
    end
    if (take_branch) begin
      out_branch_pc = stage_q.jmp ? res[PC_WIDTH-1:0] : stage_q.src3[PC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StIdle;
      stage_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (busy) begin
      if (in_flush) begin
        state_q  <= StIdle;
        stage_q  <= '0;
        acc_q    <= '0;
        mcand_q  <= '0;
        mplier_q <= '0;
        cnt_q    <= '0;
      end else begin
        acc_q    <= acc_q + pp;
        mcand_q  <= mcand_q << B;
        mplier_q <= mplier_q >> B;
        if (cnt_q == '0) state_q <= StDone;
        else             cnt_q   <= cnt_q - CntW'(1);
      end
    end else begin
      stage_q <= '{live: !in_flush, op: in_alu_op, src1: in_src1, src2: in_src2,
                   src3: in_src3, pc: in_pc, idx: in_res_reg_idx,
                   wr: in_act_write_res_to_reg, ld: in_act_load_dmem,
                   st: in_act_store_dmem, jmp: in_act_jump_to_ialu_res,
                   beq: in_act_branch_eq0, bgt: in_act_branch_gt0,
                   blt: in_act_branch_lt0};
      if (!in_flush && (in_alu_op == OpMul)) begin
        state_q  <= StBusy;
        cnt_q    <= CntW'(N - 1);
        acc_q    <= '0;
        mcand_q  <= in_src1;
        mplier_q <= in_src2;
      end else begin
        state_q <= StIdle;
      end
    end
  end

endmodule

// File: doc/exec_mc.md
Name: exec_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle execute stage of the swt16 pipeline. Sits between decode and memory/writeback.
- Registers one decoded instruction. Executes an extended integer ALU op set: add/sub, logic, barrel shifts and an iterative shift-add multiplier.
- Resolves jumps and conditional branches, and drives dmem addresses.
- Stalls upstream while a multiply is in progress. Flush kills the stage and aborts a running multiply.

Parameters:
- IALU_WORD_WIDTH, 16, ALU/operand width W; must be a power of two, >=8
- DMEM_ADDR_WIDTH, 12, dmem address width (<=W)
- PC_WIDTH, 12, program counter width (<=W)
- REG_IDX_WIDTH, 4, register index width
- ALU_OP_WIDTH, 4, opcode field width
- MUL_BITS_PER_CYCLE, 1, multiplier bits retired per cycle; must divide W

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_alu_op  in  ALU_OP_WIDTH  operation select
- in_flush  in  1  kill current/incoming instruction
- in_src1, in_src2, in_src3  in  W each  operands (src3 = branch target / store data)
- in_pc  in  PC_WIDTH  instruction PC
- in_res_reg_idx  in  REG_IDX_WIDTH  destination register
- in_act_write_res_to_reg, in_act_load_dmem, in_act_store_dmem, in_act_jump_to_ialu_res  in  1 each  action flags
- in_act_branch_eq0, in_act_branch_gt0, in_act_branch_lt0  in  1 each  branch conditions on ALU result
- out_stall  out  1  upstream must hold inputs
- out_valid  out  1  outputs carry a live instruction this cycle
- out_res  out  W  ALU result
- out_res_reg_idx  out  REG_IDX_WIDTH
- out_pc  out  PC_WIDTH
- out_act_write_res_to_reg, out_act_load_dmem, out_act_store_dmem  out  1 each
- out_dmem_rd_addr, out_dmem_wr_addr  out  DMEM_ADDR_WIDTH
- out_dmem_wr_word  out  W
- out_set_pc, out_flush  out  1 each
- out_branch_pc  out  PC_WIDTH

Behaviour:
- Reset (reset==0 at an edge):
  - all stage registers cleared; state IDLE; multiplier accumulator and counter cleared
  - every output is 0 in the following cycle, including out_stall and out_valid
- Capture: stage registers load all in_* when out_stall==0. They hold while out_stall==1.
- Ops:
  - 0 ADD: src1+src2, modulo 2^W
  - 1 SUB: src1-src2, modulo 2^W
  - 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA: shift src1 by src2[$clog2(W)-1:0]; SRA sign-fills
  - 8 PASS2: src2
  - 9 MUL: low W bits of src1*src2
  - 10+: res=0, no fault
- States:
  - IDLE: non-MUL ops are single cycle. Outputs are combinational from the stage registers in the cycle after capture; out_valid=1 unless the flush flag is set.
  - IDLE->BUSY: when a MUL is captured. Counter loads N-1, with N=W/MUL_BITS_PER_CYCLE.
  - BUSY: out_stall=1, out_valid=0, all action/branch outputs 0. Each cycle retires MUL_BITS_PER_CYCLE multiplier bits, LSB first. At counter==0 go to DONE, so BUSY lasts exactly N cycles.
  - DONE: one cycle. out_stall=0, out_valid=1, out_res=product. Branch/store logic uses the product. Next edge returns to IDLE, or to BUSY if another MUL is captured.
- Flush:
  - Captured in_flush=1 makes a bubble: out_valid=0 and all outputs 0.
  - in_flush=1 sampled while BUSY aborts: next state IDLE, stage registers cleared, out_stall=0 the next cycle, no result emitted.
- Branch/jump:
  - jump: set_pc=flush=1, branch_pc=res[PC_WIDTH-1:0]
  - otherwise, when the condition holds (eq0: res==0; gt0: msb==0 and res!=0; lt0: msb==1): set_pc=flush=1, branch_pc=src3[PC_WIDTH-1:0]
  - jump has priority over branch
  - only asserted when out_valid=1
- Memory:
  - load: rd_addr=src1[DMEM_ADDR_WIDTH-1:0]
  - store: wr_addr=res[DMEM_ADDR_WIDTH-1:0], wr_word=src3
  - both 0 when not active or when out_valid=0
- Reset mid-BUSY: reset wins; IDLE next cycle, no result, out_stall=0.

Test Plan:
- Reset: hold reset=0 for 3 cycles with arbitrary inputs -> all outputs 0. Release, then ADD 0x0003+0x0004 -> next cycle out_res=0x0007, out_valid=1.
- MUL 0x0123*0x0010, W=16, MUL_BITS_PER_CYCLE=1 -> out_stall=1 for exactly 16 cycles, then DONE cycle with out_res=0x1230, out_valid=1. A following ADD is captured at the end of DONE.
- MUL overflow 0x8000*0x0003 -> out_res=0x8000. SRA 0x8000 by 3 -> 0xF000. SRL 0x8000 by 3 -> 0x1000. SLL 0x0001 by 15 -> 0x8000.
- Branch: SUB 5-7 with lt0, src3=0x0ABC -> out_res=0xFFFE, set_pc=flush=1, branch_pc=0xABC. The same instruction with gt0 -> set_pc=0. Jump+lt0 -> branch_pc=res[11:0].
- Flush: in_flush=1 at BUSY cycle 5 of a MUL -> stall drops the next cycle, no out_valid pulse. Captured flushed STORE -> wr_addr=wr_word=0, set_pc=0.
- Reset at BUSY cycle 8 -> IDLE next cycle, outputs 0. A new MUL 0x0002*0x0003 then yields 0x0006 after 16 stall cycles.
